// File: rtl/fft_pingpong_buf_ctrl.sv
// Ping-pong input buffer controller: fills two RAM banks with whole frames and drains full banks to the FFT.
// Latency: zero cycles from s_valid to the RAM write; one cycle from read issue to m_valid.
// Backpressure: s_ready drops while the write bank is full; m_ready low freezes the RAM read so m_data holds.
module fft_pingpong_buf_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter bit BIT_REV    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [ADDR_WIDTH:0]   mem_rd_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [1:0]            bank_full
);

  // Index of the final sample in a frame (N-1).
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  rd_state_t             state;
  logic                  wb;
  logic                  rb;
  logic [ADDR_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH-1:0] rcnt;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_accept;
  logic                  wr_last;
  logic                  rd_issue;
  logic                  rd_last;
  logic [1:0]            bank_full_nxt;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = v[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

  // Write side is purely combinational into the RAM; the writer never targets a full bank.
  assign s_ready     = !bank_full[wb] && !flush;
  assign wr_accept   = s_valid && s_ready;
  assign wr_last     = wr_accept && (wcnt == LAST_IDX);
  assign mem_wr_en   = wr_accept;
  assign mem_wr_addr = {wb, wcnt};
  assign mem_wr_data = s_data;

  // A read is issued whenever the output register is empty or being consumed this cycle.
  assign rd_issue    = (state == READ) && !flush && (!m_valid || m_ready);
  assign rd_last     = rd_issue && (rcnt == LAST_IDX);
  assign rd_idx      = BIT_REV ? bitrev(rcnt) : rcnt;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = {rb, rd_idx};

  // The RAM holds its registered output while mem_rd_en is low, so it doubles as the output register.
  assign m_data      = mem_rd_data;

  // Set and clear can land in the same cycle; they always hit different banks, so both apply.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_last) begin
      bank_full_nxt[wb] = 1'b1;
    end
    if (rd_last) begin
      bank_full_nxt[rb] = 1'b0;
    end
  end

  // Bank occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else if (flush) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
    end
  end

  // Write pointer: index within the frame and the bank being filled; a partial frame is kept across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb   <= 1'b0;
      wcnt <= '0;
    end else if (flush) begin
      wb   <= 1'b0;
      wcnt <= '0;
    end else if (wr_accept) begin
      wcnt <= wcnt + 1'b1;
      if (wr_last) begin
        wb <= ~wb;
      end
    end
  end

  // Read FSM with the registered output valid/last; IDLE costs one bubble between back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rb      <= 1'b0;
      rcnt    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      rb      <= 1'b0;
      rcnt    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (rd_issue) begin
        m_valid <= 1'b1;
        m_last  <= (rcnt == LAST_IDX);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          rcnt <= '0;
          if (bank_full[rb]) begin
            state <= READ;
          end
        end
        READ: begin
          if (rd_issue) begin
            rcnt <= rcnt + 1'b1;
            if (rd_last) begin
              rb    <= ~rb;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_pingpong_buf_ctrl.sv
// Bench for the ping-pong buffer controller: one bit-reversed and one natural-order instance share stimulus.
// Each instance has its own behavioural RAM with a registered read port.
// A frame-level reference model (queues of accepted samples) predicts every output sample and m_last.
module tb_fft_pingpong_buf_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          m_ready;

  logic          s_ready     [2];
  logic [DW-1:0] m_data      [2];
  logic          m_valid     [2];
  logic          m_last      [2];
  logic          mem_wr_en   [2];
  logic [AW:0]   mem_wr_addr [2];
  logic [DW-1:0] mem_wr_data [2];
  logic [AW:0]   mem_rd_addr [2];
  logic          mem_rd_en   [2];
  logic [1:0]    bank_full   [2];
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] ram0 [2*N];
  logic [DW-1:0] ram1 [2*N];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // stimulus controls
  int feed_cnt = 0;
  int feed_val = 0;
  bit feed_rnd = 1'b0;
  int mr_mode  = 0;
  bit gap_chk  = 1'b0;

  // reference model state
  logic [DW-1:0] cur[$];
  logic [DW-1:0] expq [2][$];
  int            out_idx   [2];
  int            hs_total  [2];
  bit            prev_rd   [2];
  bit            prev_hold [2];
  logic [DW-1:0] prev_data [2];
  bit            have_last [2];
  int            last_cyc  [2];
  int            acc_total = 0;
  int            gaps_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fft_pingpong_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REV(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_last(m_last[0]),
    .mem_wr_en(mem_wr_en[0]), .mem_wr_addr(mem_wr_addr[0]), .mem_wr_data(mem_wr_data[0]),
    .mem_rd_addr(mem_rd_addr[0]), .mem_rd_en(mem_rd_en[0]), .mem_rd_data(rd_data0),
    .bank_full(bank_full[0])
  );

  fft_pingpong_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REV(1'b0)) u_nat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_last(m_last[1]),
    .mem_wr_en(mem_wr_en[1]), .mem_wr_addr(mem_wr_addr[1]), .mem_wr_data(mem_wr_data[1]),
    .mem_rd_addr(mem_rd_addr[1]), .mem_rd_en(mem_rd_en[1]), .mem_rd_data(rd_data1),
    .bank_full(bank_full[1])
  );

  // simple dual-port RAMs, registered read gated by rd_en
  always @(posedge clk) begin
    if (mem_wr_en[0]) ram0[mem_wr_addr[0]] <= mem_wr_data[0];
    if (mem_rd_en[0]) rd_data0 <= ram0[mem_rd_addr[0]];
    if (mem_wr_en[1]) ram1[mem_wr_addr[1]] <= mem_wr_data[1];
    if (mem_rd_en[1]) rd_data1 <= ram1[mem_rd_addr[1]];
  end

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < AW; b++) begin
      if (((k >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur.delete();
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      out_idx[i]   = 0;
      prev_rd[i]   = 1'b0;
      prev_hold[i] = 1'b0;
      have_last[i] = 1'b0;
    end
  endtask

  // reference model and output checker, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else if (flush) begin
      chk("flush_wr_en", mem_wr_en[0], 1'b0);
      chk("flush_rd_en", mem_rd_en[0], 1'b0);
      model_clear();
    end else begin
      if (s_valid && s_ready[0]) begin
        acc_total++;
        cur.push_back(s_data);
        if (cur.size() == N) begin
          for (int k = 0; k < N; k++) begin
            expq[0].push_back(cur[brev(k)]);
            expq[1].push_back(cur[k]);
          end
          cur.delete();
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (prev_rd[i]) chk("issue_to_valid", m_valid[i], 1'b1);
        if (prev_hold[i]) begin
          chk("hold_valid", m_valid[i], 1'b1);
          chk("hold_data", m_data[i], prev_data[i]);
        end
        if (m_valid[i] && m_ready) begin
          chk("out_pending", expq[i].size() > 0, 1'b1);
          if (expq[i].size() > 0) begin
            chk("out_data", m_data[i], expq[i].pop_front());
            chk("out_last", m_last[i], out_idx[i] == N - 1);
            if (gap_chk && out_idx[i] == 0 && have_last[i]) begin
              chk("frame_gap", cyc - last_cyc[i], 2);
              gaps_seen++;
            end
            if (out_idx[i] == N - 1) begin
              have_last[i] = 1'b1;
              last_cyc[i]  = cyc;
            end
            out_idx[i] = (out_idx[i] + 1) % N;
            hs_total[i]++;
          end
        end
        prev_rd[i]   = mem_rd_en[i];
        prev_hold[i] = m_valid[i] && !m_ready;
        prev_data[i] = m_data[i];
      end
    end
  end

  // source and sink drivers, updated just after each rising edge
  initial begin
    bit acc;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      acc = s_valid && s_ready[0] && rst_n;
      #1;
      if (acc) begin
        feed_cnt--;
        feed_val++;
      end
      if (feed_cnt > 0) begin
        s_valid = 1'b1;
        s_data  = feed_rnd ? DW'($urandom) : DW'(feed_val);
      end else begin
        s_valid = 1'b0;
      end
      case (mr_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic start_feed(input int n, input int v, input bit rnd);
    feed_val = v;
    feed_rnd = rnd;
    feed_cnt = n;
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int n = 0;
    while (hs_total[0] < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, hs_total[0] >= target, 1'b1);
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int n = 0;
    while (acc_total < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, acc_total >= target, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_hs;
    int base_acc;
    int t0;
    for (int i = 0; i < 2; i++) hs_total[i] = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    #23 rst_n = 1'b1;

    // reset state
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_s_ready", s_ready[i], 1'b1);
      chk("rst_bank_full", bank_full[i], 2'b00);
      chk("rst_m_valid", m_valid[i], 1'b0);
      chk("rst_m_last", m_last[i], 1'b0);
    end

    // one frame, index values, sink always ready
    mr_mode = 1;
    base_hs = hs_total[0];
    start_feed(N, 0, 1'b0);
    wait_hs(base_hs + N, 2000, "t1_drain_done");
    chk("t1_bank_full", bank_full[0], 2'b00);

    // three frames with the sink stalled for 1100 cycles
    mr_mode  = 0;
    t0       = cyc;
    base_acc = acc_total;
    base_hs  = hs_total[0];
    start_feed(3 * N, 1000, 1'b0);
    wait_acc(base_acc + 2 * N, 1200, "t2_fill_done");
    @(negedge clk); #1;
    chk("t2_s_ready_low", s_ready[0], 1'b0);
    chk("t2_bank_full", bank_full[0], 2'b11);
    while (cyc < t0 + 1100) begin
      @(negedge clk); #1;
    end
    chk("t2_acc_stalled", acc_total, base_acc + 2 * N);
    chk("t2_no_output", hs_total[0], base_hs);
    mr_mode = 1;
    wait_hs(base_hs + 3 * N, 4000, "t2_drain_done");
    chk("t2_bank_full_end", bank_full[0], 2'b00);

    // random data, random sink backpressure
    mr_mode = 2;
    base_hs = hs_total[0];
    start_feed(N, 0, 1'b1);
    wait_hs(base_hs + N, 4000, "t3_drain_done");
    mr_mode = 1;

    // partial frame discarded by flush
    base_acc = acc_total;
    base_hs  = hs_total[0];
    start_feed(300, 7000, 1'b0);
    wait_acc(base_acc + 300, 1000, "t4_partial_done");
    repeat (3) @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    @(negedge clk); #1;
    chk("t4_flush_bank_full", bank_full[0], 2'b00);
    chk("t4_flush_s_ready", s_ready[0], 1'b1);
    chk("t4_no_partial_out", hs_total[0], base_hs);
    start_feed(N, 9000, 1'b0);
    wait_hs(base_hs + N, 2000, "t4_drain_done");
    repeat (20) @(negedge clk);
    #1 chk("t4_out_count", hs_total[0], base_hs + N);

    // asynchronous reset in the middle of a drain
    base_hs = hs_total[0];
    start_feed(N, 0, 1'b1);
    wait_hs(base_hs + 200, 2000, "t5_reach_200");
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_rst_m_valid", m_valid[i], 1'b0);
      chk("t5_rst_bank_full", bank_full[i], 2'b00);
    end
    feed_cnt = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_s_ready", s_ready[0], 1'b1);
    chk("t5_s_ready_nat", s_ready[1], 1'b1);

    // two back-to-back frames: exactly one bubble between them
    gaps_seen = 0;
    gap_chk   = 1'b1;
    base_hs   = hs_total[0];
    start_feed(2 * N, 0, 1'b0);
    wait_hs(base_hs + 2 * N, 3000, "t6_drain_done");
    gap_chk = 1'b0;
    chk("t6_gaps_seen", gaps_seen, 2);
    chk("t6_bank_full", bank_full[1], 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
